// File: rtl/ksa_seq_pkg.sv
// Shared constants, register map and state encoding for the chunked 64-bit
// add/subtract sequencer.
package ksa_seq_pkg;

  localparam int unsigned CHUNK_W = 16;
  localparam int unsigned CHUNKS  = 4;
  localparam int unsigned OP_W    = CHUNK_W * CHUNKS;
  localparam int unsigned IDX_W   = $clog2(CHUNKS);

  // Word offsets (byte address bits [4:2])
  localparam logic [2:0] REG_A_LO   = 3'd0;
  localparam logic [2:0] REG_A_HI   = 3'd1;
  localparam logic [2:0] REG_B_LO   = 3'd2;
  localparam logic [2:0] REG_B_HI   = 3'd3;
  localparam logic [2:0] REG_CTRL   = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;
  localparam logic [2:0] REG_RES_LO = 3'd6;
  localparam logic [2:0] REG_RES_HI = 3'd7;

  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_SUB      = 1;
  localparam int unsigned CTRL_IRQ_EN   = 2;
  localparam int unsigned CTRL_DONE_CLR = 3;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;
  localparam int unsigned STAT_COUT = 2;
  localparam int unsigned STAT_OVF  = 3;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  // Apply Wishbone byte enables to a 32-bit register word.
  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] wdat,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = cur;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) r[8*i +: 8] = wdat[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/ksa16_cin.sv
// Combinational Kogge-Stone adder slice with carry-in folded into the bit-0
// generate term.
module ksa16_cin
  import ksa_seq_pkg::*;
(
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               cin,
  output logic [CHUNK_W-1:0] sum,
  output logic               cout
);

  localparam int unsigned LVLS = $clog2(CHUNK_W);

  logic [CHUNK_W-1:0] x;
  logic [CHUNK_W-1:0] g;
  logic [CHUNK_W-1:0] p;

  // Prefix levels at span 1,2,4,8; g[i] ends as carry out of bit i.
  always_comb begin
    x    = a ^ b;
    g    = a & b;
    p    = x;
    g[0] = g[0] | (x[0] & cin);
    for (int l = 0; l < LVLS; l++) begin
      g = g | (p & (g << (1 << l)));
      p = p & (p << (1 << l));
    end
    sum  = x ^ {g[CHUNK_W-2:0], cin};
    cout = g[CHUNK_W-1];
  end

endmodule

// File: rtl/ksa_seq_ctrl.sv
// Wishbone slave that sequences one 16-bit adder slice over four chunks to
// perform 64-bit add/subtract with busy/done status and a level interrupt.
module ksa_seq_ctrl
  import ksa_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o
);

  state_e             state;
  state_e             state_nx;
  logic [OP_W-1:0]    op_a;
  logic [OP_W-1:0]    op_b;
  logic [OP_W-1:0]    staging;
  logic [OP_W-1:0]    res;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic               sub;
  logic               irq_en;
  logic               done;
  logic               cout_f;
  logic               ovf;
  logic               busy;
  logic               hit;
  logic               acc;
  logic               wr;
  logic               ctrl_wr;
  logic               start_acc;
  logic [2:0]         word;
  logic [31:0]        rd_data;
  logic [CHUNK_W-1:0] slice_a;
  logic [CHUNK_W-1:0] slice_b;
  logic [CHUNK_W-1:0] slice_sum;
  logic               slice_cout;
  logic               unused_adr;

  assign hit        = (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign word       = wbs_adr_i[4:2];
  assign acc        = wbs_stb_i & wbs_cyc_i & hit & ~wbs_ack_o;
  assign wr         = acc & wbs_we_i;
  assign ctrl_wr    = wr & (word == REG_CTRL) & wbs_sel_i[0];
  assign start_acc  = ctrl_wr & wbs_dat_i[CTRL_START] & (state == IDLE);
  assign busy       = (state != IDLE);
  assign irq_o      = done & irq_en;
  assign unused_adr = ^wbs_adr_i[1:0];

  // Chunk mux into the single shared slice; subtract inverts B.
  assign slice_a = op_a[32'(idx) * CHUNK_W +: CHUNK_W];
  assign slice_b = op_b[32'(idx) * CHUNK_W +: CHUNK_W] ^ {CHUNK_W{sub}};

  ksa16_cin u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start_acc) state_nx = RUN;
      RUN:     if (idx == IDX_W'(CHUNKS - 1)) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    case (word)
      REG_A_LO:   rd_data = op_a[31:0];
      REG_A_HI:   rd_data = op_a[63:32];
      REG_B_LO:   rd_data = op_b[31:0];
      REG_B_HI:   rd_data = op_b[63:32];
      REG_CTRL: begin
        rd_data[CTRL_SUB]    = sub;
        rd_data[CTRL_IRQ_EN] = irq_en;
      end
      REG_STATUS: begin
        rd_data[STAT_BUSY] = busy;
        rd_data[STAT_DONE] = done;
        rd_data[STAT_COUT] = cout_f;
        rd_data[STAT_OVF]  = ovf;
      end
      REG_RES_LO: rd_data = res[31:0];
      REG_RES_HI: rd_data = res[63:32];
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      op_a      <= '0;
      op_b      <= '0;
      staging   <= '0;
      res       <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      sub       <= 1'b0;
      irq_en    <= 1'b0;
      done      <= 1'b0;
      cout_f    <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      wbs_ack_o <= acc;
      wbs_dat_o <= (acc && !wbs_we_i) ? rd_data : '0;

      // Operands and SUB are frozen while a sequence is in flight.
      if (wr && !busy) begin
        case (word)
          REG_A_LO: op_a[31:0]  <= byte_merge(op_a[31:0],  wbs_dat_i, wbs_sel_i);
          REG_A_HI: op_a[63:32] <= byte_merge(op_a[63:32], wbs_dat_i, wbs_sel_i);
          REG_B_LO: op_b[31:0]  <= byte_merge(op_b[31:0],  wbs_dat_i, wbs_sel_i);
          REG_B_HI: op_b[63:32] <= byte_merge(op_b[63:32], wbs_dat_i, wbs_sel_i);
          default: ;
        endcase
      end
      if (ctrl_wr) begin
        irq_en <= wbs_dat_i[CTRL_IRQ_EN];
        if (!busy) sub <= wbs_dat_i[CTRL_SUB];
      end

      // Completion outranks a same-cycle DONE_CLR.
      if (state == FIN) done <= 1'b1;
      else if (start_acc || (ctrl_wr && wbs_dat_i[CTRL_DONE_CLR])) done <= 1'b0;

      case (state)
        IDLE: begin
          if (start_acc) begin
            carry <= wbs_dat_i[CTRL_SUB];
            idx   <= '0;
          end
        end
        RUN: begin
          staging[32'(idx) * CHUNK_W +: CHUNK_W] <= slice_sum;
          carry <= slice_cout;
          idx   <= idx + IDX_W'(1);
        end
        FIN: begin
          res    <= staging;
          cout_f <= carry;
          ovf    <= (op_a[OP_W-1] == (op_b[OP_W-1] ^ sub)) &&
                    (staging[OP_W-1] != op_a[OP_W-1]);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ksa_seq_ctrl.sv
// Self-checking bench for ksa_seq_ctrl: directed and random 64-bit add/sub
// against a plain-arithmetic reference model, plus bus, IRQ and reset checks.
module tb_ksa_seq_ctrl;

  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [31:0] A_LO   = BASE + 32'h00;
  localparam logic [31:0] A_HI   = BASE + 32'h04;
  localparam logic [31:0] B_LO   = BASE + 32'h08;
  localparam logic [31:0] B_HI   = BASE + 32'h0C;
  localparam logic [31:0] CTRL   = BASE + 32'h10;
  localparam logic [31:0] STATUS = BASE + 32'h14;
  localparam logic [31:0] RES_LO = BASE + 32'h18;
  localparam logic [31:0] RES_HI = BASE + 32'h1C;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_i;
  logic        ack;
  logic [31:0] dat_o;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ksa_seq_ctrl dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat_i),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_o),
    .irq_o     (irq)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wb_cycle(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd);
    bit got_ack;
    got_ack = 1'b0;
    rd = '0;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    for (int i = 0; i < 16 && !got_ack; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        got_ack = 1'b1;
        rd = dat_o;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    if (!got_ack) check("ack_timeout", 64'(0), 64'(1));
  endtask

  task automatic wb_wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_cycle(1'b1, a, d, 4'hF, dummy);
  endtask

  task automatic wb_rd(input logic [31:0] a, output logic [31:0] d);
    wb_cycle(1'b0, a, 32'h0, 4'hF, d);
  endtask

  // Reference: plain 64-bit arithmetic, unsigned carry/no-borrow, signed overflow.
  task automatic model(input logic [63:0] a, input logic [63:0] b, input bit sub,
                       output logic [63:0] r, output bit co, output bit ov);
    logic [64:0] w;
    if (sub) begin
      r  = a - b;
      co = (a >= b);
      ov = (a[63] != b[63]) && (r[63] != a[63]);
    end else begin
      w  = {1'b0, a} + {1'b0, b};
      r  = w[63:0];
      co = w[64];
      ov = (a[63] == b[63]) && (r[63] != a[63]);
    end
  endtask

  task automatic load_start(input logic [63:0] a, input logic [63:0] b, input bit sub, input bit ien);
    wb_wr(A_LO, a[31:0]);
    wb_wr(A_HI, a[63:32]);
    wb_wr(B_LO, b[31:0]);
    wb_wr(B_HI, b[63:32]);
    wb_wr(CTRL, {28'h0, 1'b0, ien, sub, 1'b1});
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input bit sub, input bit ien);
    logic [63:0] r;
    bit co, ov;
    logic [31:0] lo, hi, st;
    load_start(a, b, sub, ien);
    // Sample 0 is just after the START ack edge.
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      check($sformatf("%s.busy%0d", tag, i), 64'(dut.busy), 64'(i < 5));
      check($sformatf("%s.irq%0d", tag, i), 64'(irq), 64'((i == 5) && ien));
    end
    wb_rd(RES_LO, lo);
    wb_rd(RES_HI, hi);
    wb_rd(STATUS, st);
    model(a, b, sub, r, co, ov);
    check($sformatf("%s.res", tag), {hi, lo}, r);
    check($sformatf("%s.status", tag), 64'(st), 64'({ov, co, 1'b1, 1'b0}));
  endtask

  logic [31:0] rd, exp32;
  logic [63:0] ra, rb;

  initial begin
    stb = 0; cyc = 0; we = 0; sel = 0; adr = 0; dat_i = 0;
    rst = 1'b1;
    #1;
    check("rst.ack", 64'(ack), 64'(0));
    check("rst.dat", 64'(dat_o), 64'(0));
    check("rst.irq", 64'(irq), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    wb_rd(STATUS, rd);
    check("rst.status", 64'(rd), 64'(0));

    // Directed arithmetic cases.
    run_op("add_carry32", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    run_op("add_wrap",    64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    run_op("add_ovf",     64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    run_op("sub_borrow",  64'd5, 64'd7, 1'b1, 1'b0);
    run_op("sub_ok",      64'd7, 64'd5, 1'b1, 1'b0);
    run_op("sub_ovf",     64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0);

    // Byte enables on operands; CTRL ignored without sel[0].
    wb_wr(A_LO, 32'h1122_3344);
    wb_cycle(1'b1, A_LO, 32'hAABB_CCDD, 4'b0101, rd);
    exp32 = 32'h1122_3344;
    for (int i = 0; i < 4; i++) if (i % 2 == 0) exp32[8*i +: 8] = 8'(32'hAABB_CCDD >> (8*i));
    wb_rd(A_LO, rd);
    check("be.a_lo", 64'(rd), 64'(exp32));
    wb_wr(CTRL, 32'h0);
    wb_cycle(1'b1, CTRL, 32'h6, 4'b1110, rd);
    wb_rd(CTRL, rd);
    check("be.ctrl", 64'(rd), 64'(0));

    // Writes and START during BUSY are acked but dropped.
    load_start(64'd1, 64'd2, 1'b0, 1'b0);
    wb_wr(A_LO, 32'h1234);
    wb_wr(CTRL, 32'h3);
    rd = '0;
    for (int i = 0; i < 20 && !rd[1]; i++) wb_rd(STATUS, rd);
    check("busy.status", 64'(rd), 64'(4'b0010));
    wb_rd(RES_LO, rd);
    check("busy.res", 64'(rd), 64'(3));
    wb_rd(A_LO, rd);
    check("busy.a_lo", 64'(rd), 64'(1));
    wb_rd(CTRL, rd);
    check("busy.ctrl", 64'(rd), 64'(0));
    begin
      int busy_cyc;
      busy_cyc = 0;
      for (int i = 0; i < 10; i++) begin @(posedge clk); #1; if (dut.busy) busy_cyc++; end
      check("busy.single_run", 64'(busy_cyc), 64'(0));
    end

    // IRQ follows DONE & IRQ_EN; DONE_CLR drops it right after ack.
    run_op("irq_on", 64'd10, 64'd20, 1'b0, 1'b1);
    wb_wr(CTRL, 32'hC);
    check("irq.clr", 64'(irq), 64'(0));
    wb_rd(STATUS, rd);
    check("irq.clr_status", 64'(rd), 64'(0));
    run_op("irq_off", 64'd10, 64'd20, 1'b0, 1'b0);

    // Out-of-window access: no ack, data stays 0.
    @(negedge clk);
    stb = 1; cyc = 1; we = 0; adr = BASE + 32'h20; sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("oow.ack%0d", i), 64'(ack), 64'(0));
      check($sformatf("oow.dat%0d", i), 64'(dat_o), 64'(0));
    end
    // Held strobe gives alternating single-cycle acks.
    adr = STATUS;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("hold.ack%0d", i), 64'(ack), 64'(i % 2 == 0));
      if (!ack) check($sformatf("hold.dat%0d", i), 64'(dat_o), 64'(0));
    end
    stb = 0; cyc = 0;

    // Random operands and operation.
    for (int n = 0; n < 25; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (n % 5 == 0) rb = ~ra;
      if (n % 7 == 0) rb = ra;
      run_op($sformatf("rnd%0d", n), ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset mid-RUN clears everything; a fresh op still works.
    wb_wr(CTRL, 32'h4);
    load_start(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mrst.ack", 64'(ack), 64'(0));
    check("mrst.dat", 64'(dat_o), 64'(0));
    check("mrst.irq", 64'(irq), 64'(0));
    check("mrst.busy", 64'(dut.busy), 64'(0));
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    wb_rd(STATUS, rd);
    check("mrst.status", 64'(rd), 64'(0));
    wb_rd(RES_LO, rd);
    check("mrst.res_lo", 64'(rd), 64'(0));
    wb_rd(A_LO, rd);
    check("mrst.a_lo", 64'(rd), 64'(0));
    wb_rd(CTRL, rd);
    check("mrst.ctrl", 64'(rd), 64'(0));
    run_op("post_rst", 64'd3, 64'd4, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
